// File: rtl/qtree_stream_loader.sv
// Host-side loader for QTree dataflow kernels: rebuilds postfix-encoded trees into the
// kernel heap, launches the kernel with the root pointers and hands the result back.
module qtree_stream_loader #(
   parameter int N_INPUTS    = 2,
   parameter int PTR_W       = 16,
   parameter int VAL_W       = 1,
   parameter int STACK_DEPTH = 256
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic [2+VAL_W-1:0]        s_tdata,
   input  logic                      s_tvalid,
   input  logic                      s_tlast,
   output logic                      s_tready,
   output logic                      heap_wr_valid,
   input  logic                      heap_wr_ready,
   output logic [2+4*PTR_W-1:0]      heap_wr_data,
   input  logic                      heap_ptr_valid,
   input  logic [PTR_W-1:0]          heap_ptr,
   output logic                      go_valid,
   input  logic                      go_ready,
   output logic [N_INPUTS-1:0]       root_valid,
   input  logic [N_INPUTS-1:0]       root_ready,
   output logic [N_INPUTS*PTR_W-1:0] root_ptr,
   input  logic                      kres_valid,
   output logic                      kres_ready,
   input  logic [PTR_W-1:0]          kres_ptr,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [PTR_W-1:0]          res_ptr,
   output logic                      busy,
   output logic                      err,
   output logic [1:0]                err_code
);

   localparam int SP_W   = $clog2(STACK_DEPTH) + 1;
   localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CNT_W  = $clog2(N_INPUTS + 1);
   localparam int NODE_W = 2 + 4*PTR_W;

   localparam logic [1:0] TAG_VAL  = 2'd1;
   localparam logic [1:0] TAG_NODE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_ACCEPT, S_WRITE, S_WAIT_PTR, S_LAUNCH, S_RUN, S_RESULT, S_ERROR
   } state_t;

   state_t                    state_q, state_d;
   logic [SP_W-1:0]           sp_q, sp_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NODE_W-1:0]         node_q, node_d;
   logic                      tlast_q, tlast_d;
   logic [N_INPUTS*PTR_W-1:0] root_ptr_q, root_ptr_d;
   logic [N_INPUTS-1:0]       root_valid_q, root_valid_d;
   logic [N_INPUTS-1:0]       root_done_q, root_done_d;
   logic                      go_valid_q, go_valid_d;
   logic                      go_done_q, go_done_d;
   logic [PTR_W-1:0]          res_ptr_q, res_ptr_d;
   logic                      res_valid_q, res_valid_d;
   logic                      s_tready_q, s_tready_d;
   logic                      heap_wr_valid_q, heap_wr_valid_d;
   logic                      kres_ready_q, kres_ready_d;
   logic                      busy_q, busy_d;
   logic                      err_q, err_d;
   logic [1:0]                err_code_q, err_code_d;

   logic [PTR_W-1:0]          stack_mem [STACK_DEPTH];
   logic                      push_en;
   logic [IDX_W-1:0]          base_idx;
   logic [4*PTR_W-1:0]        children;
   logic [SP_W-1:0]           sp_push;
   logic                      go_done_n;
   logic [N_INPUTS-1:0]       root_done_n;
   logic                      err_req;
   logic [1:0]                err_req_code;
   logic [1:0]                tok_tag;
   logic [VAL_W-1:0]          tok_val;

   assign tok_tag = s_tdata[1:0];
   assign tok_val = s_tdata[2 +: VAL_W];

   // Children of a QNode are the four most recent pushes, oldest in c0.
   always_comb begin
      base_idx = sp_q[IDX_W-1:0] - IDX_W'(4);
      children = '0;
      for (int i = 0; i < 4; i++) begin
         children[i*PTR_W +: PTR_W] = stack_mem[base_idx + IDX_W'(i)];
      end
   end

   always_comb begin
      state_d         = state_q;
      sp_d            = sp_q;
      cnt_d           = cnt_q;
      node_d          = node_q;
      tlast_d         = tlast_q;
      root_ptr_d      = root_ptr_q;
      root_valid_d    = root_valid_q;
      root_done_d     = root_done_q;
      go_valid_d      = go_valid_q;
      go_done_d       = go_done_q;
      res_ptr_d       = res_ptr_q;
      err_d           = err_q;
      err_code_d      = err_code_q;
      push_en         = 1'b0;
      err_req         = 1'b0;
      err_req_code    = 2'd0;
      sp_push         = sp_q + SP_W'(1);
      go_done_n       = go_done_q | (go_valid_q & go_ready);
      root_done_n     = root_done_q | (root_valid_q & root_ready);

      unique case (state_q)
         S_IDLE: state_d = S_ACCEPT;
         S_ACCEPT: begin
            if (s_tvalid && s_tready_q) begin
               tlast_d = s_tlast;
               if (tok_tag == TAG_NODE) begin
                  if (sp_q < SP_W'(4)) begin
                     err_req      = 1'b1;
                     err_req_code = 2'd2;
                  end else begin
                     node_d  = {children, TAG_NODE};
                     sp_d    = sp_q - SP_W'(4);
                     state_d = S_WRITE;
                  end
               end else if (sp_q == SP_W'(STACK_DEPTH)) begin
                  err_req      = 1'b1;
                  err_req_code = 2'd1;
               end else begin
                  node_d = '0;
                  node_d[1:0] = tok_tag;
                  if (tok_tag == TAG_VAL) begin
                     node_d[2 +: VAL_W] = tok_val;
                  end
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (heap_wr_valid_q && heap_wr_ready) begin
               state_d = S_WAIT_PTR;
            end
         end
         S_WAIT_PTR: begin
            if (heap_ptr_valid) begin
               if (!tlast_q) begin
                  push_en = 1'b1;
                  sp_d    = sp_push;
                  state_d = S_ACCEPT;
               end else if (sp_push != SP_W'(1)) begin
                  err_req      = 1'b1;
                  err_req_code = 2'd3;
               end else begin
                  // A complete tree leaves exactly its root on the stack; it goes straight out.
                  for (int k = 0; k < N_INPUTS; k++) begin
                     if (cnt_q == CNT_W'(k)) begin
                        root_ptr_d[k*PTR_W +: PTR_W] = heap_ptr;
                     end
                  end
                  cnt_d = cnt_q + CNT_W'(1);
                  sp_d  = '0;
                  if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                     state_d      = S_LAUNCH;
                     go_valid_d   = 1'b1;
                     root_valid_d = '1;
                     go_done_d    = 1'b0;
                     root_done_d  = '0;
                  end else begin
                     state_d = S_ACCEPT;
                  end
               end
            end
         end
         S_LAUNCH: begin
            go_valid_d   = go_valid_q & ~go_ready;
            root_valid_d = root_valid_q & ~root_ready;
            go_done_d    = go_done_n;
            root_done_d  = root_done_n;
            if (go_done_n && (&root_done_n)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (kres_ready_q && kres_valid) begin
               res_ptr_d = kres_ptr;
               state_d   = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_valid_q && res_ready) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase

      if (err_req) begin
         state_d = S_ERROR;
         if (!err_q) begin
            err_d      = 1'b1;
            err_code_d = err_req_code;
         end
      end

      s_tready_d      = (state_d == S_ACCEPT);
      heap_wr_valid_d = (state_d == S_WRITE);
      kres_ready_d    = (state_d == S_RUN);
      res_valid_d     = (state_d == S_RESULT);
      busy_d          = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q         <= S_IDLE;
         sp_q            <= '0;
         cnt_q           <= '0;
         node_q          <= '0;
         tlast_q         <= 1'b0;
         root_ptr_q      <= '0;
         root_valid_q    <= '0;
         root_done_q     <= '0;
         go_valid_q      <= 1'b0;
         go_done_q       <= 1'b0;
         res_ptr_q       <= '0;
         res_valid_q     <= 1'b0;
         s_tready_q      <= 1'b0;
         heap_wr_valid_q <= 1'b0;
         kres_ready_q    <= 1'b0;
         busy_q          <= 1'b0;
         err_q           <= 1'b0;
         err_code_q      <= 2'd0;
      end else begin
         state_q         <= state_d;
         sp_q            <= sp_d;
         cnt_q           <= cnt_d;
         node_q          <= node_d;
         tlast_q         <= tlast_d;
         root_ptr_q      <= root_ptr_d;
         root_valid_q    <= root_valid_d;
         root_done_q     <= root_done_d;
         go_valid_q      <= go_valid_d;
         go_done_q       <= go_done_d;
         res_ptr_q       <= res_ptr_d;
         res_valid_q     <= res_valid_d;
         s_tready_q      <= s_tready_d;
         heap_wr_valid_q <= heap_wr_valid_d;
         kres_ready_q    <= kres_ready_d;
         busy_q          <= busy_d;
         err_q           <= err_d;
         err_code_q      <= err_code_d;
      end
   end

   // Stack contents need no reset: sp alone defines what is live.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[sp_q[IDX_W-1:0]] <= heap_ptr;
      end
   end

   assign s_tready      = s_tready_q;
   assign heap_wr_valid = heap_wr_valid_q;
   assign heap_wr_data  = node_q;
   assign go_valid      = go_valid_q;
   assign root_valid    = root_valid_q;
   assign root_ptr      = root_ptr_q;
   assign kres_ready    = kres_ready_q;
   assign res_valid     = res_valid_q;
   assign res_ptr       = res_ptr_q;
   assign busy          = busy_q;
   assign err           = err_q;
   assign err_code      = err_code_q;

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed bench for qtree_stream_loader: token table with expected heap writes, plus
// hand-written launch, result, reset and error sequences; a second instance has a 4-deep stack.
module tb_qtree_stream_loader;

   localparam logic [1:0] Q_VAL  = 2'd1;
   localparam logic [1:0] Q_NODE = 2'd2;

   typedef struct {
      logic [1:0]  tag;
      logic        val;
      logic        last;
      logic [65:0] exp_wr;
   } tok_vec_t;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [2:0]  s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        sel_small = 1'b0;
   logic        heap_stall = 1'b0;

   logic        s_tvalid_m, s_tready;
   logic        heap_wr_valid, heap_wr_ready = 1'b1;
   logic [65:0] heap_wr_data;
   logic        heap_ptr_valid = 1'b0;
   logic [15:0] heap_ptr = '0;
   logic        go_valid, go_ready = 1'b0;
   logic [1:0]  root_valid, root_ready = 2'b00;
   logic [31:0] root_ptr;
   logic        kres_valid = 1'b0, kres_ready;
   logic [15:0] kres_ptr = '0;
   logic        res_valid, res_ready = 1'b0;
   logic [15:0] res_ptr;
   logic        busy, err;
   logic [1:0]  err_code;

   logic        s_tvalid_s, s_tready_s;
   logic        wr_valid_s;
   logic [65:0] wr_data_s;
   logic        ptr_valid_s = 1'b0;
   logic [15:0] ptr_s = '0;
   logic        go_valid_s, kres_ready_s, res_valid_s, busy_s, err_s;
   logic [1:0]  root_valid_s;
   logic [31:0] root_ptr_s;
   logic [15:0] res_ptr_s;
   logic [1:0]  err_code_s;

   int          vec_count = 0;
   int          miss_count = 0;
   int          wr_count = 0;
   logic [65:0] last_wr = '0;
   logic [15:0] next_ptr = 16'd1;
   logic        pend = 1'b0;
   int          go_hs = 0;
   int          root_hs [2] = '{0, 0};
   tok_vec_t    vecs [10];

   assign s_tvalid_m = s_tvalid & ~sel_small;
   assign s_tvalid_s = s_tvalid & sel_small;

   qtree_stream_loader #(.N_INPUTS(2), .PTR_W(16), .VAL_W(1), .STACK_DEPTH(256)) dut (
      .clk(clk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid_m), .s_tlast(s_tlast), .s_tready(s_tready),
      .heap_wr_valid(heap_wr_valid), .heap_wr_ready(heap_wr_ready), .heap_wr_data(heap_wr_data),
      .heap_ptr_valid(heap_ptr_valid), .heap_ptr(heap_ptr),
      .go_valid(go_valid), .go_ready(go_ready),
      .root_valid(root_valid), .root_ready(root_ready), .root_ptr(root_ptr),
      .kres_valid(kres_valid), .kres_ready(kres_ready), .kres_ptr(kres_ptr),
      .res_valid(res_valid), .res_ready(res_ready), .res_ptr(res_ptr),
      .busy(busy), .err(err), .err_code(err_code)
   );

   qtree_stream_loader #(.N_INPUTS(2), .PTR_W(16), .VAL_W(1), .STACK_DEPTH(4)) dut_small (
      .clk(clk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid_s), .s_tlast(s_tlast), .s_tready(s_tready_s),
      .heap_wr_valid(wr_valid_s), .heap_wr_ready(1'b1), .heap_wr_data(wr_data_s),
      .heap_ptr_valid(ptr_valid_s), .heap_ptr(ptr_s),
      .go_valid(go_valid_s), .go_ready(1'b0),
      .root_valid(root_valid_s), .root_ready(2'b00), .root_ptr(root_ptr_s),
      .kres_valid(1'b0), .kres_ready(kres_ready_s), .kres_ptr(16'h0000),
      .res_valid(res_valid_s), .res_ready(1'b0), .res_ptr(res_ptr_s),
      .busy(busy_s), .err(err_s), .err_code(err_code_s)
   );

   always #5 clk = ~clk;

   // Heap model: allocates sequential pointers one cycle after each write, unless stalled.
   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         pend           <= 1'b0;
         heap_ptr_valid <= 1'b0;
      end else begin
         heap_ptr_valid <= 1'b0;
         if (heap_wr_valid && heap_wr_ready) begin
            wr_count <= wr_count + 1;
            last_wr  <= heap_wr_data;
         end
         if ((heap_wr_valid && heap_wr_ready) || pend) begin
            if (heap_stall) begin
               pend <= 1'b1;
            end else begin
               pend           <= 1'b0;
               heap_ptr_valid <= 1'b1;
               heap_ptr       <= next_ptr;
               next_ptr       <= next_ptr + 16'd1;
            end
         end
      end
   end

   always @(posedge clk) begin
      ptr_valid_s <= wr_valid_s;
      if (wr_valid_s) ptr_s <= ptr_s + 16'd1;
   end

   always @(posedge clk) begin
      if (go_valid && go_ready) go_hs <= go_hs + 1;
      for (int k = 0; k < 2; k++) begin
         if (root_valid[k] && root_ready[k]) root_hs[k] <= root_hs[k] + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      vec_count++;
      miss_count++;
      $display("[TB] FAIL %s: timed out waiting, expected event within bound", name);
   endtask

   task automatic sendToken(input logic [1:0] tag, input logic val, input logic last);
      bit ok = 1'b0;
      @(negedge clk);
      s_tdata  = {val, tag};
      s_tlast  = last;
      s_tvalid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (sel_small ? s_tready_s : s_tready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(posedge clk);
      else timeoutFail("s_tready");
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic applyStimulus(input int first, input int last_idx);
      for (int i = first; i <= last_idx; i++) begin
         int c0 = wr_count;
         bit seen = 1'b0;
         sendToken(vecs[i].tag, vecs[i].val, vecs[i].last);
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (wr_count != c0) begin
               seen = 1'b1;
               break;
            end
         end
         if (seen) checkOutput($sformatf("wr_data[%0d]", i), 128'(last_wr), 128'(vecs[i].exp_wr));
         else timeoutFail($sformatf("heap_write[%0d]", i));
      end
   endtask

   task automatic waitKresReady(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (kres_ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) timeoutFail(name);
   endtask

   task automatic doReset();
      @(negedge clk);
      aresetn = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
   endtask

   initial begin
      bit seen;
      vecs[0] = '{Q_VAL,  1'b1, 1'b1, 66'h5};
      vecs[1] = '{Q_VAL,  1'b0, 1'b0, 66'h1};
      vecs[2] = '{Q_VAL,  1'b0, 1'b0, 66'h1};
      vecs[3] = '{Q_VAL,  1'b0, 1'b0, 66'h1};
      vecs[4] = '{Q_VAL,  1'b0, 1'b0, 66'h1};
      vecs[5] = '{Q_NODE, 1'b0, 1'b1, {16'h0005, 16'h0004, 16'h0003, 16'h0002, 2'd2}};
      vecs[6] = '{Q_VAL,  1'b0, 1'b1, 66'h1};
      vecs[7] = '{Q_VAL,  1'b1, 1'b1, 66'h5};
      vecs[8] = '{Q_VAL,  1'b1, 1'b1, 66'h5};
      vecs[9] = '{Q_VAL,  1'b0, 1'b1, 66'h1};

      #13;
      checkOutput("rst_busy", 128'(busy), 128'(0));
      checkOutput("rst_tready", 128'(s_tready), 128'(0));
      checkOutput("rst_err", 128'({err, err_code}), 128'(0));
      checkOutput("rst_valids", 128'({go_valid, root_valid, res_valid, heap_wr_valid, kres_ready}), 128'(0));
      checkOutput("rst_ptrs", 128'({root_ptr, res_ptr}), 128'(0));
      @(negedge clk);
      aresetn = 1'b1;

      // Batch 1 with launch back-pressure.
      applyStimulus(0, 5);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (go_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) timeoutFail("go_valid_rise");
      checkOutput("root_ptr_b1", 128'(root_ptr), 128'({16'h0006, 16'h0001}));
      for (int c = 0; c < 9; c++) begin
         checkOutput($sformatf("go_valid_c%0d", c), 128'(go_valid), 128'(c <= 5));
         checkOutput($sformatf("root_valid0_c%0d", c), 128'(root_valid[0]), 128'(c == 0));
         checkOutput($sformatf("root_valid1_c%0d", c), 128'(root_valid[1]), 128'(c <= 2));
         root_ready[0] = 1'b1;
         root_ready[1] = (c >= 2);
         go_ready      = (c >= 5);
         @(negedge clk);
      end
      checkOutput("go_hs_b1", 128'(go_hs), 128'(1));
      checkOutput("root_hs_b1", 128'({root_hs[1][7:0], root_hs[0][7:0]}), 128'({8'd1, 8'd1}));
      checkOutput("kres_ready_run", 128'(kres_ready), 128'(1));

      // Kernel result held against host back-pressure.
      kres_valid = 1'b1;
      kres_ptr   = 16'h00A5;
      @(posedge clk);
      #1;
      kres_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("res_hold_c%0d", c), 128'({res_valid, busy, res_ptr}), 128'({1'b1, 1'b1, 16'h00A5}));
      end
      res_ready = 1'b1;
      @(negedge clk);
      checkOutput("res_done", 128'({res_valid, busy}), 128'(0));

      // Batch 2 with no back-pressure.
      applyStimulus(6, 7);
      waitKresReady("kres_ready_b2");
      checkOutput("root_ptr_b2", 128'(root_ptr), 128'({16'h0008, 16'h0007}));
      checkOutput("go_hs_b2", 128'(go_hs), 128'(2));
      checkOutput("root_hs_b2", 128'({root_hs[1][7:0], root_hs[0][7:0]}), 128'({8'd2, 8'd2}));
      kres_valid = 1'b1;
      kres_ptr   = 16'h0042;
      @(posedge clk);
      #1;
      kres_valid = 1'b0;
      @(negedge clk);
      checkOutput("res_b2", 128'({res_valid, res_ptr}), 128'({1'b1, 16'h0042}));
      @(negedge clk);
      checkOutput("idle_b2", 128'(busy), 128'(0));
      res_ready = 1'b0;

      // Reset while waiting for an allocated pointer.
      heap_stall = 1'b1;
      begin
         int c0 = wr_count;
         sendToken(Q_VAL, 1'b1, 1'b0);
         seen = 1'b0;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (wr_count != c0) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) timeoutFail("stall_write");
      end
      @(negedge clk);
      checkOutput("busy_wait_ptr", 128'({busy, s_tready}), 128'({1'b1, 1'b0}));
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("mid_rst_ctrl", 128'({busy, s_tready, heap_wr_valid, go_valid, res_valid, err}), 128'(0));
      checkOutput("mid_rst_ptrs", 128'({root_ptr, res_ptr}), 128'(0));
      @(negedge clk);
      heap_stall = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
      root_ready = 2'b11;
      go_ready   = 1'b1;
      applyStimulus(8, 9);
      waitKresReady("kres_ready_b3");
      checkOutput("root_ptr_b3", 128'(root_ptr), 128'({16'h000A, 16'h0009}));

      // Underflow: QNode with only three entries on the stack.
      doReset();
      for (int i = 0; i < 3; i++) sendToken(Q_VAL, 1'b0, 1'b0);
      sendToken(Q_NODE, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("underflow_c%0d", c), 128'({err, err_code, s_tready}), 128'({1'b1, 2'd2, 1'b0}));
      end

      // Malformed tlast: two leaves closed as one tree.
      doReset();
      sendToken(Q_VAL, 1'b0, 1'b0);
      sendToken(Q_VAL, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      checkOutput("tlast_err", 128'({err, err_code, s_tready, busy}), 128'({1'b1, 2'd3, 1'b0, 1'b1}));

      // Overflow on the 4-deep instance: the fifth leaf has nowhere to go.
      sel_small = 1'b1;
      for (int i = 0; i < 5; i++) sendToken(Q_VAL, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("overflow_err", 128'({err_s, err_code_s, s_tready_s}), 128'({1'b1, 2'd1, 1'b0}));
      checkOutput("sticky_main", 128'({err, err_code}), 128'({1'b1, 2'd3}));

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/qtree_stream_loader.md
Name: qtree_stream_loader

Overview:
- Parametrised host-side loader for QTree dataflow kernels.
- Deserialises N_INPUTS postfix-encoded QTree streams from an AXI-Stream slave into the kernel heap through a write/allocate port, rebuilding node pointers on an internal stack.
- Launches the kernel with one go token and N_INPUTS root pointers, then returns the kernel's result pointer to the host.
- Re-arms for the next batch, and reports malformed streams with a sticky error code.

Parameters:
- N_INPUTS, 2, number of trees per batch and number of root-pointer channels (1..8).
- PTR_W, 16, heap pointer width.
- VAL_W, 1, leaf payload width (1 = Bool, 16 = Nat).
- STACK_DEPTH, 256, pointer-stack entries (power of two).

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- s_tdata  in  2+VAL_W  [1:0] tag (0 QNone, 1 QVal, 2 QNode, 3 QError); [2+VAL_W-1:2] leaf value.
- s_tvalid  in  1  token valid.
- s_tlast  in  1  last token of current tree.
- s_tready  out  1  token accepted when s_tvalid&s_tready.
- heap_wr_valid  out  1  node write request.
- heap_wr_ready  in  1  heap accepts request.
- heap_wr_data  out  2+4*PTR_W  node: tag[1:0], then c0..c3 pointers (c0 lowest) or leaf value in low bits, rest zero.
- heap_ptr_valid  in  1  allocated-pointer response, one per write.
- heap_ptr  in  PTR_W  allocated pointer.
- go_valid / go_ready  out/in  1  kernel start token.
- root_valid / root_ready  out/in  N_INPUTS  per-channel root handshake.
- root_ptr  out  N_INPUTS*PTR_W  root pointers, channel k at [k*PTR_W +: PTR_W].
- kres_valid / kres_ready  in/out  1  kernel result handshake.
- kres_ptr  in  PTR_W  kernel result pointer.
- res_valid / res_ready  out/in  1  host result handshake.
- res_ptr  out  PTR_W  result pointer.
- busy  out  1  high in any state but IDLE.
- err  out  1  sticky error.
- err_code  out  2  1 overflow, 2 underflow, 3 malformed tlast.

Behaviour:
- Reset (async, aresetn low):
  - state=IDLE; sp=0; tree count=0; err=0; err_code=0.
  - All valid outputs 0; res_ptr=0; root_ptr=0.
  - Reset mid-operation abandons the batch; no partial output survives.
- FSM states: IDLE, ACCEPT, WRITE, WAIT_PTR, LAUNCH, RUN, RESULT, ERROR.
- IDLE: next cycle goes to ACCEPT.
- ACCEPT: s_tready=1; s_tready is 0 in every other state. On handshake, latch the token and tlast, then check in priority order:
  - QNode with sp<4 -> ERROR, code 2.
  - Non-QNode with sp==STACK_DEPTH -> ERROR, code 1.
  - Otherwise -> WRITE.
  - QNode: children c0..c3 = stack[sp-4..sp-1]; sp -= 4 at this edge.
- WRITE: heap_wr_valid=1 with the latched node, held stable until heap_wr_ready, then -> WAIT_PTR.
- WAIT_PTR: on heap_ptr_valid, push heap_ptr (sp += 1).
  - Latched tlast, sp after push != 1 -> ERROR, code 3.
  - Latched tlast, sp after push == 1: pop into root[count], count += 1, sp=0. If count reaches N_INPUTS -> LAUNCH, else -> ACCEPT.
  - No tlast -> ACCEPT.
  - Minimum cost is 3 cycles per token.
- LAUNCH:
  - go_valid and every root_valid rise together.
  - Each handshake completes independently; its valid drops the cycle after its own ready, and a done bit prevents reissue.
  - When all N_INPUTS+1 are done -> RUN.
- RUN: kres_ready=1. On kres_valid, capture kres_ptr into res_ptr -> RESULT.
- RESULT: res_valid=1, res_ptr held until res_ready; then res_valid=0, count=0 -> IDLE (next batch).
- ERROR:
  - err=1 with err_code held; all valids 0, s_tready=0.
  - Exited only by reset.
  - First error wins; code never overwritten.
- Simultaneous events: heap_ptr_valid is ignored outside WAIT_PTR; kres_valid is ignored outside RUN.
- Stack index arithmetic is modulo STACK_DEPTH but guarded by the checks above, so wrap never occurs in legal operation.

Test Plan:
- N_INPUTS=2. Tree A = single QVal 1 (tlast). Tree B = four QVal 0 tokens then QNode (tlast). Heap model returns pointers 0x0001, 0x0002, … with 1-cycle latency.
  -> root_ptr[0]=0x0001, root_ptr[1]=0x0006.
  -> Node write data has c0..c3 = 0x0002..0x0005.
  -> go and both roots issued, one handshake each.
- Back-pressure: go_ready delayed 5 cycles, root_ready[1] delayed 2 cycles.
  -> go_valid held 5 cycles; root_valid[1] drops after its own handshake; no reissue.
- Kernel returns kres_ptr=0x00A5 while res_ready=0 for 3 cycles.
  -> res_valid held with res_ptr=0x00A5; after handshake busy=0; a second batch loads correctly.
- QNode token with sp=3 -> err=1, err_code=2, s_tready=0 thereafter.
- Two QVal tokens, second with tlast -> err_code=3. STACK_DEPTH=4 with 5 leaves -> err_code=1.
- aresetn pulsed low in WAIT_PTR mid-tree -> all outputs return to reset values immediately; a fresh batch completes normally.
